// File: rtl/cbus_rr_arbiter_pkg.sv
// Shared cache-bus types and arbiter state encoding.
package cbus_rr_arbiter_pkg;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] rdata;
    } cbus_resp_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/cbus_rr_arbiter_rr_pick.sv
// Combinational picker: first valid index at or after the start pointer, wrapping.
module rr_pick #(
    parameter int  NUM_INPUTS = 2,
    parameter int  RR_MODE    = 1,
    localparam int IDX_W      = $clog2(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] valid_i,
    input  logic [IDX_W-1:0]      ptr_i,
    output logic                  any_o,
    output logic [IDX_W-1:0]      sel_o
);

    // Scan offsets from farthest to nearest so the nearest valid index is the last one written.
    always_comb begin
        logic [IDX_W-1:0] start;
        logic [IDX_W:0]   idx;
        any_o = 1'b0;
        sel_o = '0;
        start = (RR_MODE != 0) ? ptr_i : '0;
        idx   = '0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            idx = {1'b0, start} + (IDX_W+1)'(k);
            if (idx >= (IDX_W+1)'(NUM_INPUTS)) begin
                idx = idx - (IDX_W+1)'(NUM_INPUTS);
            end
            if (valid_i[idx[IDX_W-1:0]]) begin
                any_o = 1'b1;
                sel_o = idx[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// N-to-1 cache-bus arbiter: holds a grant for a whole burst, fixed or round-robin policy.
module cbus_rr_arbiter
    import cbus_rr_arbiter_pkg::*;
#(
    parameter int NUM_INPUTS = 2,
    parameter int RR_MODE    = 1,
    parameter int CNT_W      = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  cbus_req_t  [NUM_INPUTS-1:0]          ireqs,
    output cbus_resp_t [NUM_INPUTS-1:0]          iresps,
    output cbus_req_t                            oreq,
    input  cbus_resp_t                           oresp,
    output logic       [NUM_INPUTS-1:0]          grant,
    output logic                                 busy,
    output logic       [NUM_INPUTS-1:0][CNT_W-1:0] done_cnt
);

    localparam int IDX_W = $clog2(NUM_INPUTS);

    arb_state_e                        state_q, state_d;
    logic [IDX_W-1:0]                  sel_q, sel_d;
    logic [IDX_W-1:0]                  ptr_q, ptr_d;
    logic [NUM_INPUTS-1:0]             grant_q, grant_d;
    logic [NUM_INPUTS-1:0][CNT_W-1:0]  cnt_q;

    logic [NUM_INPUTS-1:0] req_valid;
    logic                  pick_any;
    logic [IDX_W-1:0]      pick_sel;
    logic [IDX_W-1:0]      pick_ptr;
    logic                  done_evt;

    // Gather the valid bits of every master for the picker.
    always_comb begin
        req_valid = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            req_valid[i] = ireqs[i].valid;
        end
    end

    // Fixed priority always searches from index 0.
    assign pick_ptr = (RR_MODE != 0) ? ptr_q : '0;

    rr_pick #(
        .NUM_INPUTS (NUM_INPUTS),
        .RR_MODE    (RR_MODE)
    ) u_pick (
        .valid_i (req_valid),
        .ptr_i   (pick_ptr),
        .any_o   (pick_any),
        .sel_o   (pick_sel)
    );

    assign done_evt = (state_q == ST_BUSY) && oresp.ready && oresp.last;

    // State, selection, pointer and grant registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

    // Next state: grant in IDLE, release only on the final response beat.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                if (pick_any) begin
                    state_d           = ST_BUSY;
                    sel_d             = pick_sel;
                    grant_d[pick_sel] = 1'b1;
                    ptr_d             = (pick_sel == IDX_W'(NUM_INPUTS - 1)) ? '0
                                                                             : pick_sel + IDX_W'(1);
                end
            end
            ST_BUSY: begin
                if (done_evt) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Per-master completion counters, wrapping naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (done_evt) begin
            cnt_q[sel_q] <= cnt_q[sel_q] + CNT_W'(1);
        end
    end

    // Route the selected master through; everything else reads as zero.
    always_comb begin
        oreq   = '0;
        iresps = '0;
        if (state_q == ST_BUSY) begin
            oreq          = ireqs[sel_q];
            iresps[sel_q] = oresp;
        end
    end

    assign grant    = grant_q;
    assign busy     = (state_q == ST_BUSY);
    assign done_cnt = cnt_q;

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Bench: three arbiter configurations against a queue-free behavioural model, plus directed scenarios.
module tb_cbus_rr_arbiter;
    import cbus_rr_arbiter_pkg::*;

    localparam int NI = 3;

    function automatic int cfg_n(input int g);
        case (g)
            0:       return 2;
            1:       return 4;
            default: return 3;
        endcase
    endfunction

    function automatic int cfg_rr(input int g);
        return (g == 1) ? 0 : 1;
    endfunction

    logic                    clk = 1'b0;
    logic [NI-1:0]           rst;
    cbus_req_t  [7:0]        rq      [NI];
    cbus_resp_t              orsp    [NI];
    cbus_req_t               oreq_w  [NI];
    cbus_resp_t [7:0]        irsp_w  [NI];
    logic [7:0]              gnt_w   [NI];
    logic                    busy_w  [NI];
    logic [7:0][15:0]        cnt_w   [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int N = cfg_n(g);
        cbus_resp_t [N-1:0]       irs;
        logic [N-1:0]             gn;
        logic [N-1:0][15:0]       dc;

        cbus_rr_arbiter #(
            .NUM_INPUTS (N),
            .RR_MODE    (cfg_rr(g)),
            .CNT_W      (16)
        ) u_dut (
            .clk      (clk),
            .reset    (rst[g]),
            .ireqs    (rq[g][N-1:0]),
            .iresps   (irs),
            .oreq     (oreq_w[g]),
            .oresp    (orsp[g]),
            .grant    (gn),
            .busy     (busy_w[g]),
            .done_cnt (dc)
        );

        assign irsp_w[g] = (8*$bits(cbus_resp_t))'(irs);
        assign gnt_w[g]  = 8'(gn);
        assign cnt_w[g]  = 128'(dc);
    end

    // Behavioural model state: owner index, next search start, completion tallies.
    bit busy_m  [NI];
    int sel_m   [NI];
    int ptr_m   [NI];
    int cnt_m   [NI][8];
    bit fin_m   [NI];
    int fin_idx [NI];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int g, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d got %0h want %0h", nm, g, act, exp);
        end
    endtask

    task automatic compare_all();
        logic [7:0]       eg;
        cbus_req_t        er;
        cbus_resp_t [7:0] ers;
        logic [7:0][15:0] ec;
        for (int g = 0; g < NI; g++) begin
            eg  = '0;
            er  = '0;
            ers = '0;
            if (busy_m[g]) begin
                eg[sel_m[g]]  = 1'b1;
                er            = rq[g][sel_m[g]];
                ers[sel_m[g]] = orsp[g];
            end
            for (int i = 0; i < 8; i++) ec[i] = 16'(cnt_m[g][i]);
            chk("grant",    g, 512'(gnt_w[g]),  512'(eg));
            chk("busy",     g, 512'(busy_w[g]), 512'(busy_m[g]));
            chk("oreq",     g, 512'(oreq_w[g]), 512'(er));
            chk("iresps",   g, 512'(irsp_w[g]), 512'(ers));
            chk("done_cnt", g, 512'(cnt_w[g]),  512'(ec));
        end
    endtask

    task automatic model_step();
        int  n;
        int  start;
        int  idx;
        bit  found;
        for (int g = 0; g < NI; g++) begin
            n      = cfg_n(g);
            fin_m[g] = 1'b0;
            if (rst[g]) begin
                busy_m[g] = 1'b0;
                sel_m[g]  = 0;
                ptr_m[g]  = 0;
                for (int i = 0; i < 8; i++) cnt_m[g][i] = 0;
            end else if (!busy_m[g]) begin
                start = (cfg_rr(g) != 0) ? ptr_m[g] : 0;
                found = 1'b0;
                for (int k = 0; k < n; k++) begin
                    idx = (start + k) % n;
                    if (!found && rq[g][idx].valid) begin
                        found     = 1'b1;
                        busy_m[g] = 1'b1;
                        sel_m[g]  = idx;
                        ptr_m[g]  = (idx + 1) % n;
                    end
                end
            end else if (orsp[g].ready && orsp[g].last) begin
                busy_m[g]  = 1'b0;
                fin_m[g]   = 1'b1;
                fin_idx[g] = sel_m[g];
                cnt_m[g][sel_m[g]] = (cnt_m[g][sel_m[g]] + 1) % 65536;
            end
        end
    endtask

    // One clock: check at the falling edge, advance the model, return just after the rising edge.
    task automatic cycle();
        @(negedge clk);
        compare_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_resp(input int g, input bit rdy, input bit lst, input logic [31:0] d);
        orsp[g] = {rdy, lst, d};
    endtask

    task automatic drive_random();
        int n;
        for (int g = 0; g < NI; g++) begin
            n      = cfg_n(g);
            rst[g] = ($urandom_range(299) == 0);
            for (int i = 0; i < n; i++) begin
                if (rq[g][i].valid) begin
                    if (fin_m[g] && fin_idx[g] == i) rq[g][i].valid = 1'b0;
                    else if (busy_m[g] && sel_m[g] == i && $urandom_range(49) == 0) rq[g][i].valid = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    rq[g][i] = {1'b1, 1'($urandom), 32'($urandom), 32'($urandom)};
                end
            end
            orsp[g] = {1'($urandom), ($urandom_range(2) == 0), 32'($urandom)};
        end
    endtask

    initial begin : main
        logic [7:0] ord [6];
        ord[0] = 8'h1; ord[1] = 8'h2; ord[2] = 8'h4;
        ord[3] = 8'h1; ord[4] = 8'h2; ord[5] = 8'h4;

        rst = '1;
        for (int g = 0; g < NI; g++) begin
            rq[g]   = '0;
            orsp[g] = '0;
            busy_m[g] = 1'b0; sel_m[g] = 0; ptr_m[g] = 0; fin_m[g] = 1'b0; fin_idx[g] = 0;
            for (int i = 0; i < 8; i++) cnt_m[g][i] = 0;
        end
        cycle();
        cycle();
        rst = '0;
        chk("rst_grant", 0, 512'(gnt_w[0]), 512'd0);
        chk("rst_busy",  1, 512'(busy_w[1]), 512'd0);

        // Single request: input 1 does a 4-beat read on the two-input arbiter.
        rq[0][1] = {1'b1, 1'b0, 32'h0000_1000, 32'h0};
        cycle();
        chk("A_grant", 0, 512'(gnt_w[0]), 512'h2);
        chk("A_oreq_valid", 0, 512'(oreq_w[0].valid), 512'd1);
        for (int b = 0; b < 4; b++) begin
            set_resp(0, 1'b1, (b == 3), 32'hA0 + 32'(b));
            cycle();
        end
        rq[0][1] = '0;
        set_resp(0, 1'b0, 1'b0, 32'h0);
        chk("A_idle", 0, 512'(busy_w[0]), 512'd0);
        chk("A_cnt",  0, 512'(cnt_w[0]), 512'h0001_0000);
        cycle();

        // Fixed priority: inputs 0 and 2 always valid, single-beat transactions.
        rq[1][0] = {1'b1, 1'b0, 32'h10, 32'h0};
        rq[1][2] = {1'b1, 1'b1, 32'h20, 32'h5};
        set_resp(1, 1'b1, 1'b1, 32'h77);
        for (int t = 0; t < 5; t++) begin
            cycle();
            chk("B_prio", 1, 512'(gnt_w[1]), 512'h1);
            cycle();
        end
        rq[1] = '0;
        set_resp(1, 1'b0, 1'b0, 32'h0);
        chk("B_cnt", 1, 512'(cnt_w[1]), 512'h5);
        cycle();

        // Round-robin fairness on three inputs.
        for (int i = 0; i < 3; i++) rq[2][i] = {1'b1, 1'b0, 32'(i), 32'h0};
        set_resp(2, 1'b1, 1'b1, 32'h55);
        for (int t = 0; t < 6; t++) begin
            cycle();
            chk("C_order", 2, 512'(gnt_w[2]), 512'(ord[t]));
            cycle();
        end
        rq[2] = '0;
        chk("C_cnt", 2, 512'(cnt_w[2]), 512'h0002_0002_0002);

        // Wrap: after granting input 1 the pointer sits at 2; a lone input 0 must still win.
        rq[2][1] = {1'b1, 1'b0, 32'h31, 32'h0};
        cycle();
        chk("W_g1", 2, 512'(gnt_w[2]), 512'h2);
        cycle();
        rq[2] = '0;
        rq[2][0] = {1'b1, 1'b0, 32'h30, 32'h0};
        cycle();
        chk("W_wrap", 2, 512'(gnt_w[2]), 512'h1);
        cycle();
        for (int i = 0; i < 3; i++) rq[2][i] = {1'b1, 1'b1, 32'h40 + 32'(i), 32'h9};
        cycle();
        chk("W_ptr1", 2, 512'(gnt_w[2]), 512'h2);
        cycle();
        rq[2] = '0;
        set_resp(2, 1'b0, 1'b0, 32'h0);
        cycle();

        // Burst hold: input 0 writes 8 beats, input 1 shows up at beat 3.
        rq[0][0] = {1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF};
        cycle();
        chk("D_grant0", 0, 512'(gnt_w[0]), 512'h1);
        for (int b = 0; b < 8; b++) begin
            if (b == 2) rq[0][1] = {1'b1, 1'b0, 32'h3000, 32'h0};
            set_resp(0, 1'b1, (b == 7), 32'hB0 + 32'(b));
            cycle();
            if (b < 7) chk("D_hold", 0, 512'(gnt_w[0]), 512'h1);
        end
        chk("D_gap", 0, 512'(gnt_w[0]), 512'h0);
        rq[0][0] = '0;
        set_resp(0, 1'b0, 1'b0, 32'h0);
        cycle();
        chk("D_grant1", 0, 512'(gnt_w[0]), 512'h2);
        set_resp(0, 1'b1, 1'b1, 32'hC0);
        cycle();
        rq[0] = '0;
        set_resp(0, 1'b0, 1'b0, 32'h0);
        cycle();

        // Reset mid-burst: input 1 granted with the pointer at 2, reset at beat 2 of 4.
        rq[2][1] = {1'b1, 1'b0, 32'h50, 32'h0};
        cycle();
        chk("R_grant", 2, 512'(gnt_w[2]), 512'h2);
        set_resp(2, 1'b1, 1'b0, 32'hE0);
        cycle();
        rst[2] = 1'b1;
        set_resp(2, 1'b1, 1'b0, 32'hE1);
        cycle();
        rst[2] = 1'b0;
        set_resp(2, 1'b0, 1'b0, 32'h0);
        chk("R_busy",  2, 512'(busy_w[2]), 512'd0);
        chk("R_grant0", 2, 512'(gnt_w[2]), 512'd0);
        chk("R_oreq",  2, 512'(oreq_w[2].valid), 512'd0);
        chk("R_cnt",   2, 512'(cnt_w[2]), 512'd0);
        for (int i = 0; i < 3; i++) rq[2][i] = {1'b1, 1'b0, 32'h60 + 32'(i), 32'h0};
        cycle();
        chk("R_ptr0", 2, 512'(gnt_w[2]), 512'h1);
        set_resp(2, 1'b1, 1'b1, 32'h0);
        cycle();
        rq[2] = '0;
        set_resp(2, 1'b0, 1'b0, 32'h0);
        cycle();

        // Randomised traffic on all three configurations.
        for (int c = 0; c < 3000; c++) begin
            drive_random();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cbus_rr_arbiter.md
# cbus_rr_arbiter

Parametrised N-to-1 arbiter for the cache bus (cbus) that sits between the cache layer (ICache, DCache, and any uncached or extra masters) and the single external cbus port. It generalises the fixed two-input arbiter to `NUM_INPUTS` masters and adds a selectable fixed-priority or round-robin policy. It holds a grant for a whole burst, ending on the response beat with `last`. It also exposes the grant and per-input completion counts for debug and performance monitoring.

## Interface
- `NUM_INPUTS`, default 2: number of cbus masters, 2..8; index 0 is highest priority in fixed mode.
- `RR_MODE`, default 1: 0 selects fixed priority (lowest index wins); 1 selects round-robin.
- `CNT_W`, default 16: width of the per-input completion counters.

Ports, clock and reset first:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `ireqs`, in, `NUM_INPUTS` x `cbus_req_t`: master requests; element 0 maps to index 0.
- `iresps`, out, `NUM_INPUTS` x `cbus_resp_t`: per-master responses.
- `oreq`, out, `cbus_req_t`: request to the memory side.
- `oresp`, in, `cbus_resp_t`: response from the memory side.
- `grant`, out, `NUM_INPUTS`: one-hot grant; all zero when idle.
- `busy`, out, 1: a transaction is in progress.
- `done_cnt`, out, `NUM_INPUTS` x `CNT_W`: completed transactions per input.

## Operation
- There are two states, IDLE and BUSY.
- In IDLE:
  - The arbiter examines `ireqs[i].valid` for all inputs.
  - If any input is valid, it registers the selected index `sel`, moves to BUSY and sets `grant[sel]`.
- Selection in fixed-priority mode: the lowest valid index wins.
- Selection in round-robin mode:
  - Search starts at pointer `ptr` and wraps modulo `NUM_INPUTS`; the first valid index wins.
  - On each grant, `ptr` becomes `sel+1`, wrapping `NUM_INPUTS-1` to 0.
- In BUSY:
  - `oreq` equals `ireqs[sel]`, combinational pass-through.
  - `iresps[sel]` equals `oresp`.
  - All other `iresps` are zero.
- A transaction completes on a cycle with `oresp.ready && oresp.last`. On that edge:
  - the state returns to IDLE;
  - `done_cnt[sel]` increments, wrapping at `2^CNT_W`.
- In IDLE, `oreq` and every `iresps` are all-zero, so `oreq.valid` is 0.
- Masters must hold their request stable until they see `last`. If the granted master drops `valid` mid-burst:
  - `oreq.valid` follows it low;
  - the arbiter stays in BUSY until `ready && last`.
- Requests from non-granted inputs are ignored. They are neither acknowledged nor lost, and stay pending.
- `NUM_INPUTS` that is not a power of two is supported; the pointer wraps explicitly.

## Timing
- Reset values:
  - state IDLE, `ptr`=0, `sel`=0;
  - `grant`=0, `busy`=0, `oreq`=0, `iresps`=0;
  - every `done_cnt`=0.
- Arbitration latency is 1 cycle. A request that is valid at edge N appears on `oreq` in cycle N+1.
- On completion there is one idle cycle: `oreq.valid`=0 in the cycle after the `last` beat. Back-to-back grants are therefore at least 1 cycle apart.
- Simultaneous events: a new request arriving in the cycle the `last` beat completes is arbitrated in the following IDLE cycle. It is not granted in the same cycle.
- `reset` during BUSY:
  - forces IDLE on the next edge;
  - the in-flight transaction is abandoned;
  - counters clear.
- `grant` and `busy` are registered. `oreq` and `iresps` are combinational from registered `sel`/`busy` and the inputs.

## Structure
- `cbus_req_t` and `cbus_resp_t` stay in the shared common package. Add `localparam IDX_W = $clog2(NUM_INPUTS)` locally.
- One sub-module, `rr_pick`: combinational "first valid at or after `ptr`, with wrap". It takes `NUM_INPUTS` and `RR_MODE`; in fixed mode its `ptr` input is tied to 0.
- This block replaces the existing two-input arbiter instance in the cache manager, drop-in with `NUM_INPUTS=2`.

## Test plan
- **Single request:** `NUM_INPUTS`=2; input 1 requests a 4-beat read.
  - `oreq` mirrors `ireqs[1]` from the next cycle.
  - `grant`=2'b10.
  - Only `iresps[1]` sees the 4 beats.
  - `done_cnt[1]`=1.
  - IDLE 1 cycle after `last`.
- **Fixed priority:** `RR_MODE`=0, N=4; inputs 0 and 2 continuously valid, 1-beat transactions.
  - Input 0 wins every time.
  - After 5 transactions, `done_cnt` = {0,0,0,5} (index 3..0).
- **Round-robin fairness:** `RR_MODE`=1, N=3; all inputs continuously valid, 1-beat transactions.
  - Grant order is 0,1,2,0,1,2.
  - After 6 transactions each `done_cnt`=2.
- **Burst hold:** input 0 on an 8-beat write; input 1 asserts at beat 3.
  - Input 1 is not granted until the cycle after input 0's `last`.
  - `iresps[1]` stays zero throughout.
- **Reset mid-burst:** `reset` at beat 2 of 4.
  - Next cycle: `busy`=0, `grant`=0, `oreq.valid`=0, `ptr`=0, counters 0.
- **Wrap and non-power-of-two:** N=3, `ptr` at 2; only input 0 valid.
  - Input 0 is granted.
  - `ptr` becomes 1.
